// File: rtl/ethfield_pkg.sv
// rtl/ethfield_pkg.sv - mode constants and insert FSM state type for ethfield_insert
package ethfield_pkg;

    localparam logic [1:0] EFI_PASS      = 2'd0;
    localparam logic [1:0] EFI_INSERT    = 2'd1;
    localparam logic [1:0] EFI_OVERWRITE = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        FIELD,
        BODY
    } efi_state_t;

endpackage

// File: rtl/ethfield_dly.sv
// rtl/ethfield_dly.sv - strobe-gated {valid, byte} delay line used as the insert buffer
module ethfield_dly #(
    parameter int DEPTH = 6
) (
    input  logic       i_clk,
    input  logic       i_ce,
    input  logic       i_clr,
    input  logic       i_v,
    input  logic [7:0] i_byte,
    output logic       o_v,
    output logic [7:0] o_byte
);

    logic [8:0] sr [DEPTH];

    // shift {valid, byte} one stage toward the tail on every strobe
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else if (i_ce) begin
            sr[0] <= {i_v, i_byte};
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign o_v    = sr[DEPTH-1][8];
    assign o_byte = sr[DEPTH-1][7:0];

endmodule

// File: rtl/ethfield_insert.sv
// rtl/ethfield_insert.sv - inserts or overwrites an NBYTES field at byte OFFSET of a strobed byte stream
module ethfield_insert
    import ethfield_pkg::*;
#(
    parameter int OFFSET = 6,
    parameter int NBYTES = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic [1:0]            i_mode,
    input  logic [8*NBYTES-1:0]   i_field,
    input  logic                  i_v,
    input  logic [7:0]            i_byte,
    output logic                  o_v,
    output logic [7:0]            o_byte,
    output logic                  o_busy
);

    localparam int PW  = $clog2(OFFSET + NBYTES + 2);
    localparam int FW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int FBW = 8 * NBYTES;

    efi_state_t     st, st_n, st_eff;
    logic [PW-1:0]  pos, pos_n, pos_cur;
    logic [PW:0]    rel;
    logic [FW-1:0]  fcnt, fcnt_n, fcnt_cur;
    logic [1:0]     mode_q, mode_n, mode_cur;
    logic [FBW-1:0] field_q, field_n, field_cur;
    logic           busy, busy_n, done, done_n;
    logic           ov_n;
    logic [7:0]     ob_n;
    logic           start, accept, use_field, buf_v, tail_v;
    logic [7:0]     tail_byte;

    ethfield_dly #(.DEPTH(NBYTES)) u_dly (
        .i_clk  (i_clk),
        .i_ce   (i_ce),
        .i_clr  (i_reset),
        .i_v    (buf_v),
        .i_byte (i_byte),
        .o_v    (tail_v),
        .o_byte (tail_byte)
    );

    // next-state, datapath and output decode; a start byte is handled as its first state directly
    always_comb begin
        start     = i_v && !busy;
        accept    = i_v && (!busy || !done);
        mode_cur  = start ? i_mode  : mode_q;
        field_cur = start ? i_field : field_q;
        pos_cur   = start ? '0 : pos;
        fcnt_cur  = start ? '0 : fcnt;
        st_eff    = st;
        if (start) st_eff = (i_mode == EFI_INSERT && OFFSET == 0) ? FIELD : HEAD;
        rel       = {1'b0, pos_cur} - (PW+1)'(OFFSET);

        st_n      = st;
        pos_n     = pos;
        fcnt_n    = fcnt;
        mode_n    = mode_q;
        field_n   = field_q;
        busy_n    = busy;
        done_n    = done;
        ov_n      = o_v;
        ob_n      = o_byte;
        buf_v     = 1'b0;
        use_field = 1'b0;

        if (i_ce) begin
            mode_n  = mode_cur;
            field_n = field_cur;
            fcnt_n  = fcnt_cur;
            if (start) begin
                busy_n = 1'b1;
                done_n = 1'b0;
            end else if (busy && !i_v) begin
                done_n = 1'b1;
            end
            if (accept) pos_n = (pos_cur == '1) ? pos_cur : pos_cur + PW'(1);
            else if (!i_v && !o_v) pos_n = '0;

            case (st_eff)
                HEAD: begin
                    if (accept) begin
                        ov_n = 1'b1;
                        if (mode_cur == EFI_OVERWRITE && rel < (PW+1)'(NBYTES)) begin
                            use_field = 1'b1;
                            ob_n      = field_cur[FBW-1 -: 8];
                        end else begin
                            ob_n = i_byte;
                        end
                        st_n = (mode_cur == EFI_INSERT && pos_cur == PW'(OFFSET - 1)) ? FIELD : HEAD;
                    end else begin
                        ov_n   = 1'b0;
                        busy_n = 1'b0;
                        st_n   = IDLE;
                    end
                end
                FIELD: begin
                    ov_n      = 1'b1;
                    use_field = 1'b1;
                    ob_n      = field_cur[FBW-1 -: 8];
                    buf_v     = accept;
                    fcnt_n    = fcnt_cur + FW'(1);
                    st_n      = (fcnt_cur == FW'(NBYTES - 1)) ? BODY : FIELD;
                end
                BODY: begin
                    ov_n  = tail_v;
                    ob_n  = tail_byte;
                    buf_v = accept;
                    if (!tail_v && !accept) begin
                        busy_n = 1'b0;
                        st_n   = IDLE;
                    end
                end
                default: begin
                    ov_n = 1'b0;
                    st_n = IDLE;
                end
            endcase

            if (use_field) field_n = (field_cur << 8) | (field_cur >> (FBW - 8));
        end
    end

    // state and output registers; strobe gating is folded into the next-state logic
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st      <= IDLE;
            pos     <= '0;
            fcnt    <= '0;
            mode_q  <= EFI_PASS;
            field_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            o_v     <= 1'b0;
            o_byte  <= 8'h00;
        end else begin
            st      <= st_n;
            pos     <= pos_n;
            fcnt    <= fcnt_n;
            mode_q  <= mode_n;
            field_q <= field_n;
            busy    <= busy_n;
            done    <= done_n;
            o_v     <= ov_n;
            o_byte  <= ob_n;
        end
    end

    assign o_busy = busy;

endmodule
